// File: rtl/digit_string_writer_if.sv
// ----------------------------------------------------------------------------
// digit_string_writer_if
//   Write port between the digit string writer and the display text RAM.
//   One character is transferred in every cycle where wr_en && wr_ready.
//
//   wr_en     master -> slave   write request valid
//   wr_addr   master -> slave   text-RAM address (ADDR_W bits)
//   wr_data   master -> slave   character to write
//   wr_ready  slave  -> master  text RAM accepts the current write this cycle
// ----------------------------------------------------------------------------
interface digit_string_writer_if #(
    parameter int ADDR_W = 12
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_ready;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/digit_string_writer.sv
// ----------------------------------------------------------------------------
// digit_string_writer
//   Writes six ASCII digit characters into the text RAM, most significant
//   first, at consecutive addresses starting at base_addr (wrapping modulo
//   2^ADDR_W). Leading '0' characters can be replaced by BLANK_CHAR so that
//   numbers print right-aligned; the last digit is never blanked.
//
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   start        in   1-cycle job request, sampled only while idle
//   digits       in   six ASCII chars, [47:40] most significant
//   base_addr    in   text-RAM address of the most significant character
//   blank_zeros  in   1 = suppress leading zeros
//   wr           master side of the text-RAM write port
//   busy         out  high while writes of the current job are outstanding
//   done         out  1-cycle pulse after the last write is accepted
// ----------------------------------------------------------------------------
module digit_string_writer #(
    parameter int          ADDR_W     = 12,
    parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [47:0]           digits,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  blank_zeros,
    digit_string_writer_if.master wr,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    // Job parameters captured at start; inputs are don't-care afterwards.
    logic [47:0]       digits_q;
    logic [ADDR_W-1:0] base_q;
    logic              blank_q;

    logic [2:0]        idx;
    logic              lead;

    logic [7:0]        ch;
    logic              blank_now;
    logic              accept;
    logic              launch;

    function automatic logic [7:0] char_at(input logic [47:0] d, input logic [2:0] i);
        logic [7:0] c;
        case (i)
            3'd0:    c = d[47:40];
            3'd1:    c = d[39:32];
            3'd2:    c = d[31:24];
            3'd3:    c = d[23:16];
            3'd4:    c = d[15:8];
            default: c = d[7:0];
        endcase
        return c;
    endfunction

    assign launch = (state == IDLE) && start;
    assign accept = (state == WRITE) && wr.wr_ready;

    always_comb begin
        ch        = char_at(digits_q, idx);
        // The least significant position always prints, even when it is '0'.
        blank_now = blank_q && lead && (ch == 8'h30) && (idx != 3'd5);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = WRITE;
            WRITE:   if (accept && (idx == 3'd5)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        wr.wr_en   = 1'b0;
        wr.wr_addr = '0;
        wr.wr_data = 8'h00;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            WRITE: begin
                wr.wr_en   = 1'b1;
                wr.wr_addr = base_q + ADDR_W'(idx);
                wr.wr_data = blank_now ? BLANK_CHAR : ch;
                busy       = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Job parameter capture (data only, no reset needed: outputs are masked
    // outside WRITE and WRITE is only entered through a capture).
    always_ff @(posedge clock) begin
        if (launch) begin
            digits_q <= digits;
            base_q   <= base_addr;
            blank_q  <= blank_zeros;
        end
    end

    // Character index and leading-zero tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            idx  <= 3'd0;
            lead <= 1'b0;
        end else if (launch) begin
            idx  <= 3'd0;
            lead <= 1'b1;
        end else if (accept) begin
            if (idx != 3'd5) idx <= idx + 3'd1;
            // Once a real character has been written, later zeros are significant.
            if (!blank_now) lead <= 1'b0;
        end
    end

endmodule

// File: tb/tb_digit_string_writer.sv
// ----------------------------------------------------------------------------
// tb_digit_string_writer
//   Self-checking bench for digit_string_writer: directed jobs covering
//   blanking, stalls, address wrap, ignored start and mid-job reset, then
//   randomized jobs, all compared against a reference model.
// ----------------------------------------------------------------------------
module tb_digit_string_writer;

    localparam int         ADDR_W = 12;
    localparam logic [7:0] BLANK  = 8'h20;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [47:0]       digits;
    logic [ADDR_W-1:0] base_addr;
    logic              blank_zeros;
    logic              busy;
    logic              done;

    digit_string_writer_if #(.ADDR_W(ADDR_W)) wif ();

    digit_string_writer #(
        .ADDR_W     (ADDR_W),
        .BLANK_CHAR (BLANK)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .digits      (digits),
        .base_addr   (base_addr),
        .blank_zeros (blank_zeros),
        .wr          (wif),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the expected write sequence of a job.
    int         exp_addr [6];
    logic [7:0] exp_data [6];

    function automatic logic [7:0] byte_of(input logic [47:0] d, input int i);
        logic [47:0] t;
        t = d >> (8 * (5 - i));
        return t[7:0];
    endfunction

    function automatic void build_expected(input logic [47:0] d, input int base, input bit blank);
        int nlead;
        nlead = 0;
        if (blank) begin
            while (nlead < 5 && byte_of(d, nlead) == 8'h30) nlead++;
        end
        for (int i = 0; i < 6; i++) begin
            exp_addr[i] = (base + i) % (1 << ADDR_W);
            exp_data[i] = (i < nlead) ? BLANK : byte_of(d, i);
        end
    endfunction

    // Runs one job. stall_pct: random wr_ready-low probability; stall_idx:
    // hold wr_ready low for 3 cycles on that character (-1 = none);
    // poke_start: pulse start while writing; reset_after: assert reset once
    // that many writes have been accepted (-1 = none).
    task automatic run_job(input logic [47:0] d, input int base, input bit blank,
                           input int stall_pct, input int stall_idx,
                           input bit poke_start, input int reset_after);
        int k, cyc, nstall, fixed_stalls;
        bit finished;
        logic rdy;
        build_expected(d, base, blank);

        @(negedge clock);
        digits      = d;
        base_addr   = ADDR_W'(base);
        blank_zeros = blank;
        start       = 1'b1;
        wif.wr_ready = 1'b1;
        @(negedge clock);
        start       = 1'b0;
        digits      = {$urandom, $urandom_range(0, 65535)};
        base_addr   = ADDR_W'($urandom);
        blank_zeros = $urandom_range(0, 1);

        k = 0; cyc = 0; nstall = 0; fixed_stalls = 0; finished = 1'b0;
        while (!finished && cyc < 200) begin
            cyc++;
            if (stall_idx == k && fixed_stalls < 3) begin
                rdy = 1'b0;
                fixed_stalls++;
            end else if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
                rdy = 1'b0;
            end else begin
                rdy = 1'b1;
            end
            if (!rdy) nstall++;
            wif.wr_ready = rdy;
            start = (poke_start && k == 2);
            #1;
            check("wr_en", {31'd0, wif.wr_en}, 32'd1);
            check("busy", {31'd0, busy}, 32'd1);
            check("done_early", {31'd0, done}, 32'd0);
            check($sformatf("addr[%0d]", k), {20'd0, wif.wr_addr}, exp_addr[k]);
            check($sformatf("data[%0d]", k), {24'd0, wif.wr_data}, {24'd0, exp_data[k]});

            if (reset_after >= 0 && k == reset_after) begin
                reset = 1'b1;
                @(negedge clock);
                #1;
                check("rst_wr_en", {31'd0, wif.wr_en}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_done", {31'd0, done}, 32'd0);
                check("rst_addr", {20'd0, wif.wr_addr}, 32'd0);
                check("rst_data", {24'd0, wif.wr_data}, 32'd0);
                reset = 1'b0;
                start = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clock);
                    #1;
                    check("post_rst_wr_en", {31'd0, wif.wr_en}, 32'd0);
                    check("post_rst_done", {31'd0, done}, 32'd0);
                end
                return;
            end

            if (rdy) begin
                k++;
                if (k == 6) finished = 1'b1;
            end
            @(negedge clock);
        end
        start = 1'b0;
        if (!finished) begin
            check("write_timeout", 32'd0, 32'd1);
            return;
        end
        #1;
        check("done", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_wr_en", {31'd0, wif.wr_en}, 32'd0);
        check("write_cycles", cyc, 6 + nstall);
        @(negedge clock);
        #1;
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_wr_en", {31'd0, wif.wr_en}, 32'd0);
    endtask

    function automatic logic [7:0] rand_char();
        int r;
        r = $urandom_range(0, 9);
        if (r < 5)      return 8'h30;
        else if (r < 9) return 8'(8'h30 + $urandom_range(0, 9));
        else            return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [47:0] d;
        reset        = 1'b1;
        start        = 1'b0;
        digits       = '0;
        base_addr    = '0;
        blank_zeros  = 1'b0;
        wif.wr_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("reset_wr_en", {31'd0, wif.wr_en}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_addr", {20'd0, wif.wr_addr}, 32'd0);
        check("reset_data", {24'd0, wif.wr_data}, 32'd0);
        reset = 1'b0;

        run_job("001234", 'h100, 1'b1, 0, -1, 1'b0, -1);
        run_job("000000", 'h010, 1'b1, 0, -1, 1'b0, -1);
        run_job("000000", 'h020, 1'b0, 0, -1, 1'b0, -1);
        run_job("100203", 'h030, 1'b1, 0, -1, 1'b0, -1);
        run_job("123456", 'h200, 1'b0, 0,  2, 1'b0, -1);
        run_job("000789", 'hFFE, 1'b1, 0, -1, 1'b0, -1);
        run_job("0A0012", 'h300, 1'b1, 0, -1, 1'b1, -1);
        run_job("004567", 'h400, 1'b1, 0, -1, 1'b0,  3);
        run_job("000042", 'h500, 1'b1, 0, -1, 1'b0, -1);

        for (int j = 0; j < 40; j++) begin
            for (int b = 0; b < 6; b++) d[47 - 8*b -: 8] = rand_char();
            run_job(d, $urandom_range(0, (1 << ADDR_W) - 1), $urandom_range(0, 1),
                    ($urandom_range(0, 1) == 1) ? 30 : 0, -1, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
